// File: rtl/wb_ram_responder_pkg.sv
// Shared types and widths for the Wishbone RAM responder.
package wb_ram_pkg;

  localparam int WB_DATA_W = 32;
  localparam int WB_SEL_W  = 4;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} wb_ram_state_t;

  typedef logic [29:0] wb_word_adr_t;

endpackage

// File: rtl/wb_ram_responder_if.sv
// Wishbone classic-cycle bus between an initiator (master) and the RAM responder (slave).
interface wb_ram_responder_if;
  import wb_ram_pkg::*;

  wb_word_adr_t         wb_adr;
  logic [WB_DATA_W-1:0] wb_dat_w;
  logic [WB_DATA_W-1:0] wb_dat_r;
  logic [WB_SEL_W-1:0]  wb_sel;
  logic                 wb_cyc;
  logic                 wb_stb;
  logic                 wb_we;
  logic                 wb_ack;
  logic                 wb_err;

  modport master (
    output wb_adr, wb_dat_w, wb_sel, wb_cyc, wb_stb, wb_we,
    input  wb_dat_r, wb_ack, wb_err
  );

  modport slave (
    input  wb_adr, wb_dat_w, wb_sel, wb_cyc, wb_stb, wb_we,
    output wb_dat_r, wb_ack, wb_err
  );

endinterface

// File: rtl/wb_ram_responder_array.sv
// Single-port word RAM with per-byte write enables and a registered read port.
// The read register only loads on i_rd_en, so it holds the last read word otherwise.
module wb_ram_array
  import wb_ram_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clock,
  input  logic                  i_rst,
  input  logic [DEPTH_LOG2-1:0] i_addr,
  input  logic [WB_SEL_W-1:0]   i_wr_be,
  input  logic [WB_DATA_W-1:0]  i_wdat,
  input  logic                  i_rd_en,
  output logic [WB_DATA_W-1:0]  o_rdat
);

  logic [WB_DATA_W-1:0] r_mem [2**DEPTH_LOG2];
  logic [WB_DATA_W-1:0] r_rdat;

  always_ff @(posedge clock) begin
    for (int i = 0; i < WB_SEL_W; i++) begin
      if (i_wr_be[i]) begin
        r_mem[i_addr][8*i +: 8] <= i_wdat[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (i_rst) begin
      r_rdat <= '0;
    end else if (i_rd_en) begin
      r_rdat <= r_mem[i_addr];
    end
  end

  assign o_rdat = r_rdat;

endmodule

// File: rtl/wb_ram_responder.sv
// Wishbone classic responder over a byte-lane RAM with WAIT_CYCLES programmable wait states.
// Optional WB_RAM_RANGE_ERR_EN: out-of-range requests end with wb_err instead of wrapping.
module wb_ram_responder
  import wb_ram_pkg::*;
#(
  parameter int           DEPTH_LOG2  = 10,
  parameter wb_word_adr_t BASE_ADR    = 30'h0,
  parameter int           WAIT_CYCLES = 1
) (
  input  logic              clock,
  input  logic              reset,
  wb_ram_responder_if.slave wb
);

  wb_ram_state_t        r_state;
  wb_ram_state_t        w_state_nxt;
  logic [3:0]           r_cnt;
  logic [3:0]           w_cnt_nxt;
  wb_word_adr_t         r_adr;
  logic [WB_DATA_W-1:0] r_dat_w;
  logic [WB_SEL_W-1:0]  r_sel;
  logic                 r_we;
  logic                 r_ack;
  logic                 r_err;

  logic                  w_req;
  logic                  w_latch;
  logic                  w_enter_resp;
  wb_word_adr_t          w_adr_cur;
  logic [WB_DATA_W-1:0]  w_dat_cur;
  logic [WB_SEL_W-1:0]   w_sel_cur;
  logic                  w_we_cur;
  logic [DEPTH_LOG2-1:0] w_offset;
  logic                  w_in_range;
  logic                  w_ram_acc;
  logic                  w_ram_rd;
  logic [WB_SEL_W-1:0]   w_ram_be;
  logic [WB_DATA_W-1:0]  w_rdat;

  assign w_req = wb.wb_cyc & wb.wb_stb;

  // With zero wait states RESP is entered on the accepting edge, so the live bus feeds the RAM.
  assign w_adr_cur = (r_state == IDLE) ? wb.wb_adr   : r_adr;
  assign w_dat_cur = (r_state == IDLE) ? wb.wb_dat_w : r_dat_w;
  assign w_sel_cur = (r_state == IDLE) ? wb.wb_sel   : r_sel;
  assign w_we_cur  = (r_state == IDLE) ? wb.wb_we    : r_we;

`ifdef WB_RAM_RANGE_ERR_EN
  wb_word_adr_t w_rel;
  assign w_rel      = w_adr_cur - BASE_ADR;
  assign w_offset   = w_rel[DEPTH_LOG2-1:0];
  assign w_in_range = ((w_rel >> DEPTH_LOG2) == '0);
`else
  assign w_offset   = DEPTH_LOG2'(w_adr_cur - BASE_ADR);
  assign w_in_range = 1'b1;
`endif

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_latch      = 1'b0;
    w_enter_resp = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req) begin
          w_latch = 1'b1;
          if (WAIT_CYCLES == 0) begin
            w_state_nxt  = RESP;
            w_enter_resp = 1'b1;
          end else begin
            w_state_nxt = WAIT;
            w_cnt_nxt   = 4'(WAIT_CYCLES - 1);
          end
        end
      end
      WAIT: begin
        if (!wb.wb_cyc) begin
          w_state_nxt = IDLE;
        end else if (r_cnt == 4'd0) begin
          w_state_nxt  = RESP;
          w_enter_resp = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ack   <= w_enter_resp & w_in_range;
      r_err   <= w_enter_resp & ~w_in_range;
    end
  end

  always_ff @(posedge clock) begin
    if (w_latch) begin
      r_adr   <= wb.wb_adr;
      r_dat_w <= wb.wb_dat_w;
      r_sel   <= wb.wb_sel;
      r_we    <= wb.wb_we;
    end
  end

  // A reset on the commit edge drops the access entirely.
  assign w_ram_acc = w_enter_resp & w_in_range & ~reset;
  assign w_ram_rd  = w_ram_acc & ~w_we_cur;
  assign w_ram_be  = (w_ram_acc & w_we_cur) ? w_sel_cur : '0;

  wb_ram_array #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_ram (
    .clock   (clock),
    .i_rst   (reset),
    .i_addr  (w_offset),
    .i_wr_be (w_ram_be),
    .i_wdat  (w_dat_cur),
    .i_rd_en (w_ram_rd),
    .o_rdat  (w_rdat)
  );

  assign wb.wb_dat_r = w_rdat;
  assign wb.wb_ack   = r_ack;
  assign wb.wb_err   = r_err;

endmodule

// File: tb/tb_wb_ram_responder.sv
// Bench for wb_ram_responder: directed scenarios plus randomized traffic against a memory model.
module tb_wb_ram_responder;
  import wb_ram_pkg::*;

  localparam int           DL1    = 6;
  localparam int           DEPTH1 = 1 << DL1;
  localparam wb_word_adr_t BASE1  = 30'h100;
  localparam int           WAIT1  = 1;
  localparam int           LAT1   = WAIT1 + 1;

  logic clock;
  logic reset;
  int   n_tests;
  int   n_fail;

  wb_ram_responder_if b1 ();
  wb_ram_responder_if b0 ();

  wb_ram_responder #(.DEPTH_LOG2(DL1), .BASE_ADR(BASE1), .WAIT_CYCLES(WAIT1)) dut1 (
    .clock (clock), .reset (reset), .wb (b1)
  );

  wb_ram_responder #(.DEPTH_LOG2(10), .BASE_ADR(30'h0), .WAIT_CYCLES(0)) dut0 (
    .clock (clock), .reset (reset), .wb (b0)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

  // Behavioural memory image and expected read-data register of dut1.
  logic [31:0] m_mem1 [DEPTH1];
  logic [31:0] m_dr1;

  function automatic bit m_inrange(wb_word_adr_t a);
`ifdef WB_RAM_RANGE_ERR_EN
    wb_word_adr_t d;
    d = a - BASE1;
    return d < wb_word_adr_t'(DEPTH1);
`else
    return (a == a);
`endif
  endfunction

  function automatic int m_off(wb_word_adr_t a);
    wb_word_adr_t d;
    d = a - BASE1;
    return int'(d % wb_word_adr_t'(DEPTH1));
  endfunction

  task automatic model_txn(input wb_word_adr_t adr, input logic we, input logic [31:0] dat,
                           input logic [3:0] sel, output logic ack, output logic err,
                           output logic [31:0] rd);
    logic [31:0] mask;
    int off;
    mask = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    off  = m_off(adr);
    if (m_inrange(adr)) begin
      ack = 1'b1;
      err = 1'b0;
      if (we) m_mem1[off] = (m_mem1[off] & ~mask) | (dat & mask);
      else    m_dr1 = m_mem1[off];
    end else begin
      ack = 1'b0;
      err = 1'b1;
    end
    rd = m_dr1;
  endtask

  // Drives one dut1 transaction from just after a clock edge; returns what the bus showed.
  task automatic bus1_txn(input wb_word_adr_t adr, input logic we, input logic [31:0] dat,
                          input logic [3:0] sel, output int lat, output logic ack,
                          output logic err, output logic [31:0] rd, output logic clean);
    b1.wb_adr = adr; b1.wb_we = we; b1.wb_dat_w = dat; b1.wb_sel = sel;
    b1.wb_cyc = 1'b1; b1.wb_stb = 1'b1;
    lat = -1; ack = 1'b0; err = 1'b0; rd = b1.wb_dat_r;
    for (int i = 1; i <= 24; i++) begin
      @(posedge clock); #1;
      if (b1.wb_ack || b1.wb_err) begin
        lat = i; ack = b1.wb_ack; err = b1.wb_err; rd = b1.wb_dat_r;
        break;
      end
    end
    b1.wb_cyc = 1'b0; b1.wb_stb = 1'b0; b1.wb_we = 1'b0;
    @(posedge clock); #1;
    clean = !b1.wb_ack && !b1.wb_err;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    m_dr1 = '0;
    n_tests++; if (b1.wb_ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack1: got %b expected 0", b1.wb_ack); end
    n_tests++; if (b1.wb_err !== 1'b0) begin n_fail++; $display("FAIL reset_err1: got %b expected 0", b1.wb_err); end
    n_tests++; if (b1.wb_dat_r !== 32'h0) begin n_fail++; $display("FAIL reset_dat1: got %h expected 0", b1.wb_dat_r); end
    n_tests++; if (b0.wb_ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack0: got %b expected 0", b0.wb_ack); end
    n_tests++; if (b0.wb_err !== 1'b0) begin n_fail++; $display("FAIL reset_err0: got %b expected 0", b0.wb_err); end
    n_tests++; if (b0.wb_dat_r !== 32'h0) begin n_fail++; $display("FAIL reset_dat0: got %h expected 0", b0.wb_dat_r); end
  endtask

  task automatic test_fill;
    logic ea, ee, a, e, cl; logic [31:0] er, rd; int lat;
    int bad;
    bad = 0;
    for (int i = 0; i < DEPTH1; i++) begin
      logic [31:0] d;
      d = $urandom;
      model_txn(BASE1 + wb_word_adr_t'(i), 1'b1, d, 4'hF, ea, ee, er);
      bus1_txn(BASE1 + wb_word_adr_t'(i), 1'b1, d, 4'hF, lat, a, e, rd, cl);
      if (a !== 1'b1 || e !== 1'b0 || lat != LAT1) bad++;
    end
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL fill: %0d writes misterminated, expected 0", bad); end
  endtask

  task automatic test_basic_read;
    logic ea, ee, a, e, cl; logic [31:0] er, rd; int lat;
    model_txn(BASE1, 1'b1, 32'hDEADBEEF, 4'hF, ea, ee, er);
    bus1_txn(BASE1, 1'b1, 32'hDEADBEEF, 4'hF, lat, a, e, rd, cl);
    n_tests++; if (a !== 1'b1) begin n_fail++; $display("FAIL preload_ack: got %b expected 1", a); end
    model_txn(BASE1, 1'b0, 32'h0, 4'hF, ea, ee, er);
    bus1_txn(BASE1, 1'b0, 32'h0, 4'hF, lat, a, e, rd, cl);
    n_tests++; if (lat != LAT1) begin n_fail++; $display("FAIL read_latency: got %0d expected %0d", lat, LAT1); end
    n_tests++; if (a !== 1'b1 || e !== 1'b0) begin n_fail++; $display("FAIL read_term: got ack=%b err=%b expected ack=1 err=0", a, e); end
    n_tests++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL read_data: got %h expected deadbeef", rd); end
    n_tests++; if (cl !== 1'b1) begin n_fail++; $display("FAIL read_pulse: ack/err still high after one cycle"); end
  endtask

  task automatic test_byte_lanes;
    logic ea, ee, a, e, cl; logic [31:0] er, rd, prev; int lat;
    wb_word_adr_t adr;
    adr = BASE1 + 30'd9;
    model_txn(adr, 1'b1, 32'h11223344, 4'hF, ea, ee, er);
    bus1_txn(adr, 1'b1, 32'h11223344, 4'hF, lat, a, e, rd, cl);
    prev = m_dr1;
    model_txn(adr, 1'b1, 32'hAABBCCDD, 4'b0101, ea, ee, er);
    bus1_txn(adr, 1'b1, 32'hAABBCCDD, 4'b0101, lat, a, e, rd, cl);
    n_tests++; if (rd !== prev) begin n_fail++; $display("FAIL write_holds_dat_r: got %h expected %h", rd, prev); end
    model_txn(adr, 1'b0, 32'h0, 4'hF, ea, ee, er);
    bus1_txn(adr, 1'b0, 32'h0, 4'hF, lat, a, e, rd, cl);
    n_tests++; if (rd !== 32'h11BB33DD) begin n_fail++; $display("FAIL byte_lanes: got %h expected 11bb33dd", rd); end
    model_txn(adr, 1'b1, 32'hFFFFFFFF, 4'b0000, ea, ee, er);
    bus1_txn(adr, 1'b1, 32'hFFFFFFFF, 4'b0000, lat, a, e, rd, cl);
    n_tests++; if (a !== 1'b1) begin n_fail++; $display("FAIL sel0_ack: got %b expected 1", a); end
    model_txn(adr, 1'b0, 32'h0, 4'hF, ea, ee, er);
    bus1_txn(adr, 1'b0, 32'h0, 4'hF, lat, a, e, rd, cl);
    n_tests++; if (rd !== 32'h11BB33DD) begin n_fail++; $display("FAIL sel0_unchanged: got %h expected 11bb33dd", rd); end
  endtask

  task automatic test_abort;
    logic ea, ee, a, e, cl; logic [31:0] er, rd; int lat, seen;
    wb_word_adr_t adr;
    adr = BASE1 + 30'd3;
    b1.wb_adr = adr; b1.wb_we = 1'b0; b1.wb_sel = 4'hF; b1.wb_cyc = 1'b1; b1.wb_stb = 1'b1;
    @(posedge clock); #1;
    b1.wb_cyc = 1'b0; b1.wb_stb = 1'b0;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clock); #1;
      if (b1.wb_ack || b1.wb_err) seen++;
    end
    n_tests++; if (seen != 0) begin n_fail++; $display("FAIL abort_no_term: got %0d pulses expected 0", seen); end
    n_tests++; if (b1.wb_dat_r !== m_dr1) begin n_fail++; $display("FAIL abort_dat_r: got %h expected %h", b1.wb_dat_r, m_dr1); end
    model_txn(adr, 1'b1, 32'h0BADF00D, 4'hF, ea, ee, er);
    bus1_txn(adr, 1'b1, 32'h0BADF00D, 4'hF, lat, a, e, rd, cl);
    n_tests++; if (a !== 1'b1 || lat != LAT1) begin n_fail++; $display("FAIL abort_next_write: got ack=%b lat=%0d expected ack=1 lat=%0d", a, lat, LAT1); end
    // stb dropping during WAIT must not cancel the accepted read
    model_txn(adr, 1'b0, 32'h0, 4'hF, ea, ee, er);
    b1.wb_adr = adr; b1.wb_we = 1'b0; b1.wb_cyc = 1'b1; b1.wb_stb = 1'b1;
    @(posedge clock); #1;
    b1.wb_stb = 1'b0;
    @(posedge clock); #1;
    n_tests++; if (b1.wb_ack !== 1'b1) begin n_fail++; $display("FAIL stb_drop_ack: got %b expected 1", b1.wb_ack); end
    n_tests++; if (b1.wb_dat_r !== 32'h0BADF00D) begin n_fail++; $display("FAIL stb_drop_data: got %h expected 0badf00d", b1.wb_dat_r); end
    b1.wb_cyc = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_range;
    logic ea, ee, a, e, cl; logic [31:0] er, rd, exp0; int lat;
    wb_word_adr_t adr;
    adr = BASE1 + wb_word_adr_t'(DEPTH1);
`ifdef WB_RAM_RANGE_ERR_EN
    exp0 = m_mem1[0];
`else
    exp0 = 32'h55AA55AA;
`endif
    model_txn(adr, 1'b1, 32'h55AA55AA, 4'hF, ea, ee, er);
    bus1_txn(adr, 1'b1, 32'h55AA55AA, 4'hF, lat, a, e, rd, cl);
    n_tests++; if (a !== ea || e !== ee) begin n_fail++; $display("FAIL range_term: got ack=%b err=%b expected ack=%b err=%b", a, e, ea, ee); end
    n_tests++; if (cl !== 1'b1) begin n_fail++; $display("FAIL range_pulse: termination longer than one cycle"); end
    model_txn(BASE1, 1'b0, 32'h0, 4'hF, ea, ee, er);
    bus1_txn(BASE1, 1'b0, 32'h0, 4'hF, lat, a, e, rd, cl);
    n_tests++; if (rd !== exp0) begin n_fail++; $display("FAIL range_word0: got %h expected %h", rd, exp0); end
  endtask

  task automatic test_reset_in_wait;
    logic ea, ee, a, e, cl; logic [31:0] er, rd, old; int lat;
    wb_word_adr_t adr;
    adr = BASE1 + 30'd5;
    old = m_mem1[5];
    b1.wb_adr = adr; b1.wb_we = 1'b1; b1.wb_dat_w = ~old; b1.wb_sel = 4'hF;
    b1.wb_cyc = 1'b1; b1.wb_stb = 1'b1;
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    n_tests++; if (b1.wb_ack !== 1'b0 || b1.wb_err !== 1'b0) begin n_fail++; $display("FAIL rst_wait_term: got ack=%b err=%b expected 0 0", b1.wb_ack, b1.wb_err); end
    reset = 1'b0; b1.wb_cyc = 1'b0; b1.wb_stb = 1'b0; b1.wb_we = 1'b0;
    m_dr1 = '0;
    @(posedge clock); #1;
    n_tests++; if (b1.wb_ack !== 1'b0) begin n_fail++; $display("FAIL rst_wait_late_ack: got %b expected 0", b1.wb_ack); end
    model_txn(adr, 1'b0, 32'h0, 4'hF, ea, ee, er);
    bus1_txn(adr, 1'b0, 32'h0, 4'hF, lat, a, e, rd, cl);
    n_tests++; if (rd !== old) begin n_fail++; $display("FAIL rst_wait_data: got %h expected %h", rd, old); end
  endtask

  task automatic test_random;
    logic ea, ee, a, e, cl, we; logic [31:0] er, rd, dat; logic [3:0] sel; int lat;
    wb_word_adr_t adr;
    for (int t = 0; t < 60; t++) begin
      case ($urandom_range(0, 5))
        0:       adr = BASE1 + wb_word_adr_t'(DEPTH1) + wb_word_adr_t'($urandom_range(0, 7));
        1:       adr = BASE1 - 30'd1 - wb_word_adr_t'($urandom_range(0, 7));
        default: adr = BASE1 + wb_word_adr_t'($urandom_range(0, DEPTH1 - 1));
      endcase
      we  = 1'($urandom_range(0, 1));
      dat = $urandom;
      sel = 4'($urandom_range(0, 15));
      model_txn(adr, we, dat, sel, ea, ee, er);
      bus1_txn(adr, we, dat, sel, lat, a, e, rd, cl);
      n_tests++; if (lat != LAT1) begin n_fail++; $display("FAIL rand_lat[%0d]: got %0d expected %0d", t, lat, LAT1); end
      n_tests++; if (a !== ea || e !== ee) begin n_fail++; $display("FAIL rand_term[%0d]: got ack=%b err=%b expected ack=%b err=%b", t, a, e, ea, ee); end
      n_tests++; if (rd !== er) begin n_fail++; $display("FAIL rand_data[%0d]: adr=%h we=%b got %h expected %h", t, adr, we, rd, er); end
      n_tests++; if (cl !== 1'b1) begin n_fail++; $display("FAIL rand_pulse[%0d]: termination longer than one cycle", t); end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] d [4];
    int acks, last, first, gap_bad, both, errs, rd_bad, extra;
    for (int i = 0; i < 4; i++) d[i] = $urandom;
    for (int pass = 0; pass < 2; pass++) begin
      acks = 0; last = -1; first = -1; gap_bad = 0; both = 0; errs = 0; rd_bad = 0; extra = 0;
      b0.wb_adr = '0; b0.wb_we = (pass == 0); b0.wb_dat_w = d[0]; b0.wb_sel = 4'hF;
      b0.wb_cyc = 1'b1; b0.wb_stb = 1'b1;
      for (int c = 1; c <= 40 && acks < 4; c++) begin
        @(posedge clock); #1;
        if (b0.wb_ack && b0.wb_err) both++;
        if (b0.wb_err) errs++;
        if (b0.wb_ack) begin
          if (last < 0) first = c;
          else if (c - last != 2) gap_bad++;
          if (pass == 1 && b0.wb_dat_r !== d[acks]) rd_bad++;
          last = c;
          acks++;
          if (acks < 4) begin
            b0.wb_adr = wb_word_adr_t'(acks);
            b0.wb_dat_w = d[acks];
          end
        end
      end
      b0.wb_cyc = 1'b0; b0.wb_stb = 1'b0;
      for (int c = 0; c < 4; c++) begin
        @(posedge clock); #1;
        if (b0.wb_ack || b0.wb_err) extra++;
      end
      n_tests++; if (acks != 4) begin n_fail++; $display("FAIL b2b_acks[%0d]: got %0d expected 4", pass, acks); end
      n_tests++; if (first != 1) begin n_fail++; $display("FAIL b2b_first[%0d]: got %0d expected 1", pass, first); end
      n_tests++; if (gap_bad != 0) begin n_fail++; $display("FAIL b2b_spacing[%0d]: %0d gaps not 2 cycles, expected 0", pass, gap_bad); end
      n_tests++; if (both != 0 || errs != 0) begin n_fail++; $display("FAIL b2b_err[%0d]: got both=%0d err=%0d expected 0 0", pass, both, errs); end
      n_tests++; if (extra != 0) begin n_fail++; $display("FAIL b2b_extra[%0d]: got %0d stray pulses expected 0", pass, extra); end
      n_tests++; if (rd_bad != 0) begin n_fail++; $display("FAIL b2b_data[%0d]: got %0d bad reads expected 0", pass, rd_bad); end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b1;
    b1.wb_adr = '0; b1.wb_dat_w = '0; b1.wb_sel = '0; b1.wb_cyc = 1'b0; b1.wb_stb = 1'b0; b1.wb_we = 1'b0;
    b0.wb_adr = '0; b0.wb_dat_w = '0; b0.wb_sel = '0; b0.wb_cyc = 1'b0; b0.wb_stb = 1'b0; b0.wb_we = 1'b0;
    test_reset();
    test_fill();
    test_basic_read();
    test_byte_lanes();
    test_abort();
    test_range();
    test_reset_in_wait();
    test_random();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
